edge_pulse_multi: RTL
=====================

Name: edge_pulse_multi

Overview:
- Parametrised successor to the single-channel rising-edge one-shot.
- Watches CHANNELS independent level inputs. Each channel has a runtime-selectable edge mode (off/rise/fall/both).
- Each detected edge produces an output pulse PULSE_LEN cycles long, and increments a saturating per-channel event counter.
- Sits between slow/pushbutton/SPI-side control levels and single-cycle strobe consumers, e.g. reset or transaction-start logic.

Parameters:
- CHANNELS, 4, number of independent channels (>=1).
- PULSE_LEN, 1, output pulse length in clk cycles (>=1).
- CNT_W, 8, width of each per-channel event counter (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in  input  CHANNELS  level inputs, one bit per channel.
- mode  input  2*CHANNELS  per-channel edge mode, channel i at bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
- clr  input  CHANNELS  per-channel synchronous counter clear.
- out  output  CHANNELS  per-channel pulse outputs, registered.
- any_out  output  1  registered OR of all out bits, same cycle as out.
- count  output  CNT_W*CHANNELS  per-channel event counters, channel i at [CNT_W*(i+1)-1:CNT_W*i].

Behaviour:
- Reset (asynchronous, active-high): clears per-channel last-sample, timer, out, any_out, count. All outputs read 0 while reset is high.
- After reset the last-sample is 0. An input already high at reset release produces a rise edge on the first clock (legacy-compatible).
- Edge detect per channel on each clk edge, from sampled in versus last:
  - rise = in & ~last
  - fall = ~in & last
  - detected = (mode[0] & rise) | (mode[1] & fall)
  - last <= in, every cycle, regardless of mode.
- Latency: out goes high on the clk edge that samples the qualifying input. It is visible in the cycle after the input change is sampled; 1 cycle, identical to legacy.
- Pulse timer, per channel, width $clog2(PULSE_LEN+1):
  - On a detected edge: timer <= PULSE_LEN-1, out <= 1.
  - Else if timer != 0: timer <= timer-1, out stays 1.
  - Else: out <= 0.
  - Result: an isolated edge gives exactly PULSE_LEN cycles of out high.
- Retrigger: an edge detected while out is high reloads the timer, extending the pulse to PULSE_LEN cycles after the new edge. No gap is inserted.
  - Example: mode 11, PULSE_LEN=1, in high for one cycle → out high 2 consecutive cycles.
- Mode change: takes effect on the next sample. An in-flight pulse always completes; mode 00 suppresses only new detections.
- Counter, per channel:
  - clr high → count <= 0. Clear has priority; an edge detected in the same cycle is not counted.
  - Else a detected edge increments count, saturating at 2^CNT_W-1.
  - Retriggering edges are counted.
- Channels are fully independent; simultaneous edges on multiple channels are each handled.
- any_out <= |next_out, registered alongside out.

Optional Feature:
- Macro: EDGE_PULSE_SYNC_EN.
- Defined: each in bit passes through a 2-flop synchroniser (reset to 0) before edge detection. Latency becomes 3 cycles from the input change to out. After reset release, a high input produces its rise pulse 3 cycles later.
- Undefined: in feeds edge detection directly, 1-cycle latency; the caller guarantees in is synchronous to clk.

Decomposition:
- Shared package edge_pulse_pkg:
  - mode encodings MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11
  - function for timer width
- One natural sub-module: edge_pulse_chan. It holds a single channel's synchroniser (under macro), last-sample, timer, out and counter.
- The top generates CHANNELS instances and builds any_out.

Test Plan:
- Reset: CHANNELS=4, PULSE_LEN=3, CNT_W=4, mode=all 01. Hold in=0, then in[0] 0→1 and hold high 10 cycles → out[0] high exactly 3 cycles starting 1 cycle after the sample; count0=1; other channels 0.
- Modes: ch1=10, ch2=11, ch3=00; toggle all inputs 0→1→0 with 8 cycles between changes:
  - ch1: one pulse, on the fall; count 1.
  - ch2: two pulses; count 2.
  - ch3: no pulse; count 0.
  - ch0 (rise): one pulse; count 1.
- Retrigger: PULSE_LEN=3, mode 11; in high for 1 cycle → out high 4 consecutive cycles (edges at t, t+1); count=2.
- Saturation/clear: CNT_W=4; 20 rise edges on ch0 → count0 stops at 15. Assert clr[0] in the same cycle as an edge → count0=0 next cycle, the edge is not counted, and out[0] still pulses.
- Reset mid-pulse: assert reset asynchronously (between clock edges) while out[2] is high with the timer at 2 → out and count drop to 0 immediately, not waiting for a clock edge. Release reset with in[2]=1 → rise pulse 1 cycle later, or 3 cycles later with EDGE_PULSE_SYNC_EN.
- any_out: edges on ch0 and ch3 in the same cycle → out[0], out[3] and any_out all high that cycle. any_out falls only after both pulses end.

Source files
------------

// File: rtl/edge_pulse_pkg.sv
// Shared definitions for the multi-channel edge pulse generator.
// Build option: EDGE_PULSE_SYNC_EN adds a 2-flop input synchroniser per channel.
package edge_pulse_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_t;

    // Timer must hold values 0..PULSE_LEN-1; sized as clog2(PULSE_LEN+1) so PULSE_LEN=1 still gets 1 bit.
    function automatic int unsigned timer_width(input int unsigned pulse_len);
        return $clog2(pulse_len + 1);
    endfunction

endpackage

// File: rtl/edge_pulse_chan.sv
// One channel of edge_pulse_multi: optional synchroniser, last-sample,
// pulse timer, registered pulse output and saturating event counter.
// Build option: EDGE_PULSE_SYNC_EN inserts a 2-flop synchroniser on in.
module edge_pulse_chan
    import edge_pulse_pkg::*;
#(
    parameter int unsigned PULSE_LEN = 1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic [1:0]       mode,
    input  logic             clr,
    output logic             out,
    output logic             out_next,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned     TW    = timer_width(PULSE_LEN);
    localparam logic [TW-1:0]   TLOAD = TW'(PULSE_LEN - 1);

    logic          sample;
    logic          last;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic          rise;
    logic          fall;
    logic          detected;
    mode_t         mode_sel;

`ifdef EDGE_PULSE_SYNC_EN
    logic [1:0] sync_q;

    // Two-stage synchroniser ahead of edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[0], in};
    end

    assign sample = sync_q[1];
`else
    assign sample = in;
`endif

    assign mode_sel = mode_t'(mode);
    assign rise     = sample & ~last;
    assign fall     = ~sample & last;

    // Qualify raw edges with the channel's edge mode
    always_comb begin
        detected = 1'b0;
        if ((mode_sel == MODE_RISE) || (mode_sel == MODE_BOTH)) detected = detected | rise;
        if ((mode_sel == MODE_FALL) || (mode_sel == MODE_BOTH)) detected = detected | fall;
    end

    // Pulse timer: a detection (re)loads, otherwise count down while the pulse lasts
    always_comb begin
        timer_next = timer;
        out_next   = 1'b0;
        if (detected) begin
            timer_next = TLOAD;
            out_next   = 1'b1;
        end else if (timer != '0) begin
            timer_next = timer - TW'(1);
            out_next   = 1'b1;
        end
    end

    // Last-sample, timer and pulse output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last  <= 1'b0;
            timer <= '0;
            out   <= 1'b0;
        end else begin
            last  <= sample;
            timer <= timer_next;
            out   <= out_next;
        end
    end

    // Saturating event counter; clear wins over a same-cycle edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                           count <= '0;
        else if (clr)                        count <= '0;
        else if (detected && (count != '1))  count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/edge_pulse_multi.sv
// Multi-channel edge-to-pulse generator with per-channel edge modes and
// saturating event counters; any_out is the registered OR of all pulses.
// Build option: EDGE_PULSE_SYNC_EN adds input synchronisers (3-cycle latency).
module edge_pulse_multi
    import edge_pulse_pkg::*;
#(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned PULSE_LEN = 1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       in,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [CHANNELS-1:0]       clr,
    output logic [CHANNELS-1:0]       out,
    output logic                      any_out,
    output logic [CNT_W*CHANNELS-1:0] count
);

    logic [CHANNELS-1:0] out_next;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        edge_pulse_chan #(
            .PULSE_LEN (PULSE_LEN),
            .CNT_W     (CNT_W)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .in       (in[i]),
            .mode     (mode[2*i +: 2]),
            .clr      (clr[i]),
            .out      (out[i]),
            .out_next (out_next[i]),
            .count    (count[CNT_W*i +: CNT_W])
        );
    end

    // any_out registered from the channels' next pulse values so it aligns with out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) any_out <= 1'b0;
        else       any_out <= |out_next;
    end

endmodule
